// File: rtl/cejmu_pkg.sv
// Shared types for the cejmu accumulate/ALU tile.
package cejmu_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/cejmu_addsub_sat.sv
// Combinational WIDTH-bit add/subtract with carry/borrow flag and optional clamp.
module cejmu_addsub_sat #(
  parameter int WIDTH  = 8,
  parameter int SAT_EN = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] r,
  output logic             ovf
);

  logic [WIDTH:0] raw;

  // One extra bit: carry on add, borrow (a < b) on subtract.
  always_comb begin
    raw = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    ovf = raw[WIDTH];
    r   = raw[WIDTH-1:0];
    if ((SAT_EN != 0) && ovf) begin
      r = sub ? '0 : '1;
    end
  end

endmodule

// File: rtl/cejmu_accum_alu.sv
// Multi-channel add/sub/accumulate unit with valid/ready handshake and a
// single registered result stage.
module cejmu_accum_alu
  import cejmu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SAT_EN = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic [$clog2(NUM_CH)-1:0] in_ch,
  input  logic [1:0]                in_mode,
  input  logic                      clr_all,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_ovf
);

  localparam int CHW = $clog2(NUM_CH);

  logic [WIDTH-1:0] acc_q [NUM_CH];
  logic [WIDTH-1:0] acc_d [NUM_CH];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CHW-1:0]   out_ch_q, out_ch_d;
  logic             out_ovf_q, out_ovf_d;

  mode_t            mode;
  logic             accept;
  logic [WIDTH-1:0] acc_rd;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_sub;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  assign mode     = mode_t'(in_mode);
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A coinciding clr_all makes the accumulator read as zero for this op.
  always_comb begin
    acc_rd = clr_all ? '0 : acc_q[in_ch];
    op_a   = in_a;
    op_b   = in_b;
    op_sub = 1'b0;
    case (mode)
      MODE_SUB:  op_sub = 1'b1;
      MODE_ACC:  begin
        op_a = acc_rd;
        op_b = in_a;
      end
      MODE_LOAD: op_b = '0;
      default:   ;
    endcase
  end

  cejmu_addsub_sat #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_addsub (
    .a   (op_a),
    .b   (op_b),
    .sub (op_sub),
    .r   (res),
    .ovf (res_ovf)
  );

  // Clear first, then the accepted op's write-back wins for its own channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      acc_d[i] = clr_all ? '0 : acc_q[i];
    end
    if (accept && (mode == MODE_ACC || mode == MODE_LOAD)) begin
      acc_d[in_ch] = res;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_ovf_d   = out_ovf_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = res;
      out_ch_d    = in_ch;
      out_ovf_d   = res_ovf;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cejmu_accum_alu.sv
// Directed bench: a wrapping and a saturating instance share one stimulus stream.
module tb_cejmu_accum_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a, in_b;
  logic [1:0] in_ch;
  logic [1:0] in_mode;
  logic       clr_all;
  logic       out_ready;

  logic       w_in_ready, w_out_valid, w_out_ovf;
  logic [7:0] w_out_data;
  logic [1:0] w_out_ch;
  logic       s_in_ready, s_out_valid, s_out_ovf;
  logic [7:0] s_out_data;
  logic [1:0] s_out_ch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cejmu_accum_alu #(.WIDTH(8), .NUM_CH(4), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_ch(in_ch), .in_mode(in_mode),
    .clr_all(clr_all), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_out_data), .out_ch(w_out_ch), .out_ovf(w_out_ovf)
  );

  cejmu_accum_alu #(.WIDTH(8), .NUM_CH(4), .SAT_EN(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_ch(in_ch), .in_mode(in_mode),
    .clr_all(clr_all), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_ch(s_out_ch), .out_ovf(s_out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                    input logic [1:0] ch);
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a;
    in_b     = b;
    in_ch    = ch;
    cyc();
  endtask

  task automatic chk_both(input string tag, input logic [7:0] wd, input logic wo,
                          input logic [7:0] sd, input logic so);
    chk({tag, " wrap valid"}, w_out_valid, 1'b1);
    chk({tag, " wrap data"}, w_out_data, wd);
    chk({tag, " wrap ovf"}, w_out_ovf, wo);
    chk({tag, " sat valid"}, s_out_valid, 1'b1);
    chk({tag, " sat data"}, s_out_data, sd);
    chk({tag, " sat ovf"}, s_out_ovf, so);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_ch = '0;
    in_mode = 2'b00; clr_all = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    chk("reset out_valid", w_out_valid, 1'b0);
    chk("reset out_data", w_out_data, 8'd0);
    chk("reset out_ch", w_out_ch, 2'd0);
    chk("reset out_ovf", w_out_ovf, 1'b0);
    rst = 1'b0;
    cyc();
    chk("post-reset in_ready", w_in_ready, 1'b1);

    op(2'b00, 8'd200, 8'd100, 2'd0);
    chk_both("add 200+100", 8'd44, 1'b1, 8'd255, 1'b1);
    op(2'b01, 8'd5, 8'd7, 2'd1);
    chk_both("sub 5-7", 8'd254, 1'b1, 8'd0, 1'b1);
    chk("sub out_ch", w_out_ch, 2'd1);
    op(2'b00, 8'd3, 8'd4, 2'd2);
    chk_both("add 3+4", 8'd7, 1'b0, 8'd7, 1'b0);
    chk("add out_ch", s_out_ch, 2'd2);

    op(2'b10, 8'd250, 8'd99, 2'd1);
    chk_both("acc ch1 250", 8'd250, 1'b0, 8'd250, 1'b0);
    op(2'b10, 8'd10, 8'd0, 2'd1);
    chk_both("acc ch1 +10", 8'd4, 1'b1, 8'd255, 1'b1);

    op(2'b10, 8'd10, 8'd0, 2'd0);
    chk_both("acc ch0 #1", 8'd10, 1'b0, 8'd10, 1'b0);
    op(2'b10, 8'd10, 8'd0, 2'd0);
    chk_both("acc ch0 #2", 8'd20, 1'b0, 8'd20, 1'b0);
    op(2'b10, 8'd10, 8'd0, 2'd0);
    chk_both("acc ch0 #3", 8'd30, 1'b0, 8'd30, 1'b0);
    chk("acc ch0 out_ch", w_out_ch, 2'd0);
    op(2'b10, 8'd0, 8'd0, 2'd2);
    chk_both("acc ch2 untouched", 8'd0, 1'b0, 8'd0, 1'b0);

    in_valid = 1'b0;
    cyc();
    chk("drain out_valid", w_out_valid, 1'b0);

    // Backpressure: the held ACC must not be applied during the stall.
    out_ready = 1'b0;
    op(2'b00, 8'd1, 8'd2, 2'd3);
    chk_both("bp first", 8'd3, 1'b0, 8'd3, 1'b0);
    in_mode = 2'b10; in_a = 8'd5; in_ch = 2'd2;
    for (int i = 0; i < 5; i++) begin
      chk("bp in_ready low", w_in_ready, 1'b0);
      cyc();
      chk("bp data stable", w_out_data, 8'd3);
      chk("bp valid held", w_out_valid, 1'b1);
      chk("bp ch stable", w_out_ch, 2'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", w_in_ready, 1'b1);
    cyc();
    chk_both("bp second", 8'd5, 1'b0, 8'd5, 1'b0);
    chk("bp second ch", w_out_ch, 2'd2);
    in_valid = 1'b0;
    cyc();
    chk("bp drained", w_out_valid, 1'b0);

    op(2'b11, 8'd50, 8'd77, 2'd3);
    chk_both("load ch3 50", 8'd50, 1'b0, 8'd50, 1'b0);
    clr_all = 1'b1;
    op(2'b10, 8'd9, 8'd0, 2'd3);
    chk_both("clr+acc ch3", 8'd9, 1'b0, 8'd9, 1'b0);
    clr_all = 1'b0;
    op(2'b10, 8'd1, 8'd0, 2'd3);
    chk_both("acc ch3 after clr", 8'd10, 1'b0, 8'd10, 1'b0);
    op(2'b10, 8'd0, 8'd0, 2'd0);
    chk_both("ch0 cleared", 8'd0, 1'b0, 8'd0, 1'b0);
    op(2'b10, 8'd0, 8'd0, 2'd1);
    chk_both("ch1 cleared", 8'd0, 1'b0, 8'd0, 1'b0);
    op(2'b10, 8'd0, 8'd0, 2'd2);
    chk_both("ch2 cleared", 8'd0, 1'b0, 8'd0, 1'b0);

    clr_all = 1'b1;
    op(2'b11, 8'd7, 8'd0, 2'd1);
    chk_both("clr+load ch1", 8'd7, 1'b0, 8'd7, 1'b0);
    clr_all = 1'b0;
    op(2'b10, 8'd0, 8'd0, 2'd1);
    chk_both("load wins ch1", 8'd7, 1'b0, 8'd7, 1'b0);
    op(2'b10, 8'd0, 8'd0, 2'd3);
    chk_both("ch3 cleared by load clr", 8'd0, 1'b0, 8'd0, 1'b0);

    // Reset while a result is held under backpressure.
    out_ready = 1'b0;
    op(2'b00, 8'd1, 8'd1, 2'd2);
    chk("held before rst", w_out_valid, 1'b1);
    rst = 1'b1;
    out_ready = 1'b1;
    op(2'b00, 8'd2, 8'd2, 2'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst out_valid", w_out_valid, 1'b0);
    chk("rst out_data", w_out_data, 8'd0);
    chk("rst in_ready", w_in_ready, 1'b1);
    cyc();
    chk("no output from reset-cycle op", w_out_valid, 1'b0);
    op(2'b10, 8'd0, 8'd0, 2'd1);
    chk_both("rst clears ch1", 8'd0, 1'b0, 8'd0, 1'b0);
    op(2'b10, 8'd0, 8'd0, 2'd3);
    chk_both("rst clears ch3", 8'd0, 1'b0, 8'd0, 1'b0);
    in_valid = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
